// File: rtl/signal_conflict_monitor_pkg.sv
// Shared types and fault codes for the lamp-output conflict monitor.
package tl_monitor_pkg;

   typedef enum logic [2:0] {RED, GREEN, YELLOW, DARK, MULTI} lamp_t;
   typedef enum logic [1:0] {MONITOR, FAULT, RECOVER} fsm_t;

   localparam logic [2:0] FLT_NONE      = 3'd0;
   localparam logic [2:0] FLT_CONFLICT  = 3'd1;
   localparam logic [2:0] FLT_MULTI     = 3'd2;
   localparam logic [2:0] FLT_DARK      = 3'd3;
   localparam logic [2:0] FLT_SHORT_YEL = 3'd4;
   localparam logic [2:0] FLT_ILLEGAL   = 3'd5;
   localparam logic [2:0] FLT_SHORT_GRN = 3'd6;

   function automatic lamp_t decode_lamps(logic red, logic green, logic yellow);
      case ({red, green, yellow})
         3'b100:  return RED;
         3'b010:  return GREEN;
         3'b001:  return YELLOW;
         3'b000:  return DARK;
         default: return MULTI;
      endcase
   endfunction

endpackage

// File: rtl/signal_conflict_monitor_if.sv
// Lamp lines driven by the traffic-light controller and observed by the monitor.
interface signal_conflict_monitor_if;
   logic NS_red, NS_green, NS_yellow;
   logic EW_red, EW_green, EW_yellow;

   modport master (output NS_red, NS_green, NS_yellow, EW_red, EW_green, EW_yellow);
   modport slave  (input  NS_red, NS_green, NS_yellow, EW_red, EW_green, EW_yellow);
endinterface

// File: rtl/signal_conflict_monitor_decoder.sv
// Per-approach lamp decode with registered previous state, dwell timer and dark tracking.
module approach_decoder
   import tl_monitor_pkg::*;
#(
   parameter int unsigned CNT_W    = 6,
   parameter int unsigned DARK_TOL = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             restart_i,
   input  logic             red_i,
   input  logic             green_i,
   input  logic             yellow_i,
   output lamp_t            cur_state_o,
   output lamp_t            prev_state_o,
   output logic [CNT_W-1:0] dwell_o,
   output logic             valid_o,
   output logic             dark_over_o,
   output logic             go_o
);

   lamp_t            prev_q;
   logic [CNT_W-1:0] dwell_q;
   logic             valid_q;
   logic [CNT_W:0]   dark_run;

   assign cur_state_o = decode_lamps(red_i, green_i, yellow_i);
   // A green or yellow lamp counts as "go" even inside a multi-lamp aspect.
   assign go_o        = green_i | yellow_i;

   // Consecutive dark cycles including the one being sampled now.
   assign dark_run    = (prev_q == DARK) ? {1'b0, dwell_q} + 1'b1 : (CNT_W+1)'(1);
   assign dark_over_o = (cur_state_o == DARK) && (dark_run > (CNT_W+1)'(DARK_TOL));

   always_ff @(posedge clk_i) begin
      if (rst_i || restart_i) begin
         prev_q  <= RED;
         dwell_q <= '0;
         valid_q <= 1'b0;
      end else if (cur_state_o != prev_q) begin
         prev_q  <= cur_state_o;
         dwell_q <= CNT_W'(1);
         valid_q <= 1'b1;
      end else if (dwell_q != '1) begin
         dwell_q <= dwell_q + 1'b1;
      end
   end

   assign prev_state_o = prev_q;
   assign dwell_o      = dwell_q;
   assign valid_o      = valid_q;

endmodule

// File: rtl/signal_conflict_monitor.sv
// Independent lamp-output checker: latches the first fault and requests all-red flash.
// Optional fault tally enabled by defining FAULT_LOG_EN.
module signal_conflict_monitor
   import tl_monitor_pkg::*;
#(
   parameter int unsigned MIN_GREEN   = 8,
   parameter int unsigned MIN_YELLOW  = 3,
   parameter int unsigned DARK_TOL    = 2,
   parameter int unsigned RECOVER_CYC = 4,
   parameter int unsigned CNT_W       = 6
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   signal_conflict_monitor_if.slave  lamps,
   input  logic                      i_fault_clear,
   output logic                      o_fault,
   output logic [2:0]                o_fault_code,
   output logic                      o_flash_req,
   output logic [7:0]                o_fault_count
);

   localparam int unsigned RCNT_W = $clog2(RECOVER_CYC + 1);

   lamp_t            ns_cur, ns_prev, ew_cur, ew_prev;
   logic [CNT_W-1:0] ns_dwell, ew_dwell;
   logic             ns_valid, ew_valid, ns_dark, ew_dark, ns_go, ew_go;
   logic             restart, conflict, both_red;
   logic [2:0]       ns_seq, ew_seq, seq_code, cur_code;

   fsm_t              state_q, state_d;
   logic              fault_q, fault_d;
   logic [2:0]        code_q, code_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;

   approach_decoder #(.CNT_W(CNT_W), .DARK_TOL(DARK_TOL)) u_ns (
      .clk_i(i_clk), .rst_i(i_rst), .restart_i(restart),
      .red_i(lamps.NS_red), .green_i(lamps.NS_green), .yellow_i(lamps.NS_yellow),
      .cur_state_o(ns_cur), .prev_state_o(ns_prev), .dwell_o(ns_dwell),
      .valid_o(ns_valid), .dark_over_o(ns_dark), .go_o(ns_go)
   );

   approach_decoder #(.CNT_W(CNT_W), .DARK_TOL(DARK_TOL)) u_ew (
      .clk_i(i_clk), .rst_i(i_rst), .restart_i(restart),
      .red_i(lamps.EW_red), .green_i(lamps.EW_green), .yellow_i(lamps.EW_yellow),
      .cur_state_o(ew_cur), .prev_state_o(ew_prev), .dwell_o(ew_dwell),
      .valid_o(ew_valid), .dark_over_o(ew_dark), .go_o(ew_go)
   );

   // Lowest sequencing fault code (4..6) seen on one approach this cycle.
   function automatic logic [2:0] seq_fault(lamp_t prev, lamp_t cur, logic valid,
                                            logic [CNT_W-1:0] dwell);
      if (valid && prev == YELLOW && cur == RED && dwell < CNT_W'(MIN_YELLOW))
         return FLT_SHORT_YEL;
      if ((prev == GREEN && cur == RED) || (prev == RED && cur == YELLOW) ||
          (prev == YELLOW && cur == GREEN))
         return FLT_ILLEGAL;
      if (valid && prev == GREEN && cur == YELLOW && dwell < CNT_W'(MIN_GREEN))
         return FLT_SHORT_GRN;
      return FLT_NONE;
   endfunction

   assign ns_seq   = seq_fault(ns_prev, ns_cur, ns_valid, ns_dwell);
   assign ew_seq   = seq_fault(ew_prev, ew_cur, ew_valid, ew_dwell);
   assign seq_code = (ns_seq == FLT_NONE) ? ew_seq :
                     (ew_seq == FLT_NONE) ? ns_seq :
                     (ns_seq < ew_seq)    ? ns_seq : ew_seq;

   assign conflict = ns_go && ew_go;
   assign both_red = (ns_cur == RED) && (ew_cur == RED);
   assign cur_code = conflict                          ? FLT_CONFLICT :
                     (ns_cur == MULTI || ew_cur == MULTI) ? FLT_MULTI :
                     (ns_dark || ew_dark)              ? FLT_DARK : seq_code;

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      code_d  = code_q;
      rcnt_d  = rcnt_q;
      restart = 1'b0;
      case (state_q)
         MONITOR: begin
            if (cur_code != FLT_NONE) begin
               state_d = FAULT;
               fault_d = 1'b1;
               code_d  = cur_code;
            end
         end
         FAULT: begin
            if (i_fault_clear) begin
               state_d = RECOVER;
               rcnt_d  = '0;
            end
         end
         RECOVER: begin
            if (conflict) begin
               state_d = FAULT;
            end else if (!both_red) begin
               rcnt_d = '0;
            end else if (rcnt_q == RCNT_W'(RECOVER_CYC - 1)) begin
               state_d = MONITOR;
               fault_d = 1'b0;
               code_d  = FLT_NONE;
               rcnt_d  = '0;
               restart = 1'b1;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         default: state_d = MONITOR;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= MONITOR;
         fault_q <= 1'b0;
         code_q  <= FLT_NONE;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign o_fault      = fault_q;
   assign o_fault_code = code_q;
   assign o_flash_req  = (state_q != MONITOR);

`ifdef FAULT_LOG_EN
   logic [7:0] count_q;
   logic       enter_fault;

   // Only fresh MONITOR->FAULT entries are tallied, not RECOVER re-entries.
   assign enter_fault = (state_q == MONITOR) && (cur_code != FLT_NONE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= 8'd0;
      end else if (enter_fault && count_q != 8'hff) begin
         count_q <= count_q + 8'd1;
      end
   end

   assign o_fault_count = count_q;
`else
   assign o_fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed self-checking bench for signal_conflict_monitor.
module tb_signal_conflict_monitor;

   logic       clk;
   logic       rst;
   logic       fault_clear;
   logic       fault;
   logic [2:0] fault_code;
   logic       flash_req;
   logic [7:0] fault_count;
   int         checks;
   int         failures;
   int         exp_count;

   signal_conflict_monitor_if lamps ();

   signal_conflict_monitor dut (
      .i_clk(clk),
      .i_rst(rst),
      .lamps(lamps),
      .i_fault_clear(fault_clear),
      .o_fault(fault),
      .o_fault_code(fault_code),
      .o_flash_req(flash_req),
      .o_fault_count(fault_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ns(input logic r, input logic g, input logic y);
      lamps.NS_red = r; lamps.NS_green = g; lamps.NS_yellow = y;
   endtask

   task automatic set_ew(input logic r, input logic g, input logic y);
      lamps.EW_red = r; lamps.EW_green = g; lamps.EW_yellow = y;
   endtask

   task automatic drive(input bit ns, input logic r, input logic g, input logic y);
      if (ns) set_ns(r, g, y);
      else    set_ew(r, g, y);
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_st(input string tag, input int f, input int c, input int fl);
      chk({tag, ".fault"}, int'(fault), f);
      chk({tag, ".code"}, int'(fault_code), c);
      chk({tag, ".flash"}, int'(flash_req), fl);
   endtask

   task automatic chk_count(input string tag);
`ifdef FAULT_LOG_EN
      chk({tag, ".count"}, int'(fault_count), exp_count);
`else
      chk({tag, ".count"}, int'(fault_count), 0);
`endif
   endtask

   // Clear pulse with all red, then RECOVER_CYC clean all-red cycles.
   task automatic do_recover(input string tag, input int code);
      set_ns(1, 0, 0);
      set_ew(1, 0, 0);
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      step(3);
      chk_st({tag, ".recovering"}, 1, code, 1);
      step(1);
      chk_st({tag, ".recovered"}, 0, 0, 0);
   endtask

   task automatic legal_phase(input bit ns);
      drive(ns, 0, 1, 0);
      repeat (10) begin step(1); chk_st("legal.green", 0, 0, 0); end
      drive(ns, 0, 0, 1);
      repeat (3) begin step(1); chk_st("legal.yellow", 0, 0, 0); end
      drive(ns, 1, 0, 0);
      step(1);
      chk_st("legal.red", 0, 0, 0);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      exp_count   = 0;
      rst         = 1'b1;
      fault_clear = 1'b0;
      set_ns(1, 1, 1);
      set_ew(0, 0, 0);
      step(2);
      chk_st("reset", 0, 0, 0);
      chk_count("reset");
      set_ns(1, 0, 0);
      set_ew(1, 0, 0);
      rst = 1'b0;
      step(2);
      chk_st("idle_red", 0, 0, 0);

      // Legal alternating cycle, three rounds.
      repeat (3) begin
         legal_phase(1'b1);
         legal_phase(1'b0);
      end

      // Conflict: visible only after the sampling edge.
      set_ns(0, 1, 0);
      set_ew(0, 1, 0);
      #2;
      chk_st("conflict.same_cycle", 0, 0, 0);
      step(1);
      exp_count++;
      chk_st("conflict", 1, 1, 1);
      do_recover("conflict", 1);

      // Conflict together with an NS multi-lamp aspect still reports conflict.
      set_ns(1, 1, 0);
      set_ew(0, 1, 0);
      step(1);
      exp_count++;
      chk_st("conflict_multi", 1, 1, 1);
      do_recover("conflict_multi", 1);

      // Short green: 4 cycles then yellow.
      set_ns(0, 1, 0);
      step(4);
      chk_st("short_green.pre", 0, 0, 0);
      set_ns(0, 0, 1);
      step(1);
      exp_count++;
      chk_st("short_green", 1, 6, 1);
      do_recover("short_green", 6);

      // Short yellow: 2 cycles then red.
      set_ns(0, 1, 0);
      step(10);
      set_ns(0, 0, 1);
      step(2);
      chk_st("short_yellow.pre", 0, 0, 0);
      set_ns(1, 0, 0);
      step(1);
      exp_count++;
      chk_st("short_yellow", 1, 4, 1);
      do_recover("short_yellow", 4);

      // Illegal GREEN->RED.
      set_ns(0, 1, 0);
      step(10);
      set_ns(1, 0, 0);
      step(1);
      exp_count++;
      chk_st("illegal_g2r", 1, 5, 1);
      do_recover("illegal_g2r", 5);

      // EW dark: tolerated for 2 cycles, faults on the 3rd; later conflict keeps code 3.
      set_ew(0, 0, 0);
      step(2);
      chk_st("dark.tolerated", 0, 0, 0);
      step(1);
      exp_count++;
      chk_st("dark", 1, 3, 1);
      set_ns(0, 1, 0);
      set_ew(0, 1, 0);
      step(1);
      chk_st("dark.then_conflict", 1, 3, 1);
      // Recovery interrupted by a non-red sample at recovery cycle 2.
      set_ns(1, 0, 0);
      set_ew(1, 0, 0);
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      step(1);
      set_ew(0, 1, 0);
      step(1);
      chk_st("dark.non_red", 1, 3, 1);
      set_ew(1, 0, 0);
      step(3);
      chk_st("dark.count_restarted", 1, 3, 1);
      step(1);
      chk_st("dark.recovered", 0, 0, 0);

      // Illegal RED->YELLOW, then conflict during RECOVER returns to FAULT.
      set_ns(0, 0, 1);
      step(1);
      exp_count++;
      chk_st("illegal_r2y", 1, 5, 1);
      set_ns(1, 0, 0);
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      set_ns(0, 1, 0);
      set_ew(0, 1, 0);
      step(1);
      chk_st("recover_conflict", 1, 5, 1);
      set_ns(1, 0, 0);
      set_ew(1, 0, 0);
      step(5);
      chk_st("recover_conflict.held", 1, 5, 1);
      chk_count("recover_conflict");
      do_recover("recover_conflict", 5);

      // Clear held throughout: enters RECOVER, completes only on clean all-red.
      fault_clear = 1'b1;
      step(2);
      chk_st("clear_in_monitor", 0, 0, 0);
      set_ns(0, 1, 0);
      set_ew(0, 1, 0);
      step(1);
      exp_count++;
      chk_st("clear_held.fault", 1, 1, 1);
      set_ns(1, 0, 0);
      set_ew(1, 0, 0);
      step(4);
      chk_st("clear_held.recovering", 1, 1, 1);
      step(1);
      chk_st("clear_held.recovered", 0, 0, 0);
      fault_clear = 1'b0;
      chk_count("tally");

      // Reset mid-FAULT.
      set_ew(0, 0, 1);
      set_ns(0, 1, 0);
      step(1);
      exp_count++;
      chk_st("pre_reset", 1, 1, 1);
      chk_count("pre_reset");
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      exp_count = 0;
      chk_st("mid_fault_reset", 0, 0, 0);
      chk_count("mid_fault_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/signal_conflict_monitor.md
Name: signal_conflict_monitor

Overview:
- Independent checker on the lamp outputs of the traffic-light controller: it reads the six NS/EW red/green/yellow lines that the controller drives.
- Decodes each approach's lamp state and times how long each state lasts.
- Detects conflicting, illegal or too-short aspects, then latches a fault code and a flash request.
- Sits beside the controller in the top level; its only drive back is o_flash_req, used by the fail-safe flasher.

Parameters:
- MIN_GREEN, 8, minimum legal green dwell in clock cycles.
- MIN_YELLOW, 3, minimum legal yellow dwell in clock cycles.
- DARK_TOL, 2, consecutive all-off cycles tolerated per approach before a fault.
- RECOVER_CYC, 4, consecutive all-red cycles required before leaving recovery.
- CNT_W, 6, dwell counter width; counters saturate at 2^CNT_W-1.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  synchronous, active-high reset.
- NS_red, NS_green, NS_yellow  input  1 each  NS lamp lines from the controller.
- EW_red, EW_green, EW_yellow  input  1 each  EW lamp lines from the controller.
- i_fault_clear  input  1  operator clear, level-sampled.
- o_fault  output  1  latched fault flag.
- o_fault_code  output  3  code of the first fault; 0 = none.
- o_flash_req  output  1  request all-red flash; high in FAULT and RECOVER.
- o_fault_count  output  8  saturating fault tally (see Optional Feature).

Behaviour:
- Reset (i_rst high at an edge):
  - All outputs go to 0 and the FSM goes to MONITOR.
  - Both previous-state registers are set to RED; dwell counters are 0; per-approach valid flags are 0.
  - Applies from any state, including mid-fault.
- Per-approach decode of the current inputs:
  - Exactly one lamp lit gives RED, GREEN or YELLOW.
  - No lamp lit gives DARK.
  - More than one lamp lit gives MULTI.
- Dwell counter:
  - Resets to 1 on any decoded-state change, otherwise increments, saturating.
  - The valid flag is set on the first change after reset; short-dwell checks are suppressed while valid is 0.
- Fault detection is combinational on the current decode versus the previous registered decode. Faults, in priority order (lowest code wins on simultaneous events):
  - Code 1, conflict: both approaches in {GREEN, YELLOW} in the same cycle.
  - Code 2, multi: either approach decodes MULTI.
  - Code 3, dark: an approach is DARK for more than DARK_TOL consecutive cycles.
  - Code 4, short yellow: YELLOW->RED with yellow dwell < MIN_YELLOW.
  - Code 5, illegal sequence: GREEN->RED, RED->YELLOW or YELLOW->GREEN.
  - Code 6, short green: GREEN->YELLOW with green dwell < MIN_GREEN.
- Latency: a fault present at edge k sets o_fault and o_fault_code at that edge, so they are visible during cycle k+1.
- FSM states:
  - MONITOR: detection active; on any fault go to FAULT and latch the code.
  - FAULT: code held; further faults ignored; i_fault_clear=1 goes to RECOVER.
  - RECOVER: counts consecutive cycles with both approaches RED.
    - Reaching RECOVER_CYC goes to MONITOR: o_fault and o_fault_code clear, valid flags clear, and dwell counters restart.
    - Any non-RED sample resets the count.
    - A conflict (code 1) returns the FSM to FAULT with the original code kept.
- Clear behaviour:
  - i_fault_clear in MONITOR or RECOVER is ignored.
  - If clear is held while a fault is still present, the FSM still enters RECOVER; recovery only completes on clean all-red cycles.
- o_flash_req = 1 in FAULT and RECOVER, 0 in MONITOR.

Optional Feature:
- Macro: FAULT_LOG_EN.
- Defined: o_fault_count increments by 1 on every MONITOR->FAULT transition. It saturates at 255, is cleared only by i_rst, and RECOVER->FAULT re-entries are not counted.
- Undefined: o_fault_count is tied to 8'd0 and no counter logic is synthesised; the port is always present.

Decomposition:
- Package tl_monitor_pkg holds:
  - the lamp-state enum (RED, GREEN, YELLOW, DARK, MULTI);
  - the FSM enum (MONITOR, FAULT, RECOVER);
  - localparam fault codes FLT_NONE=0 through FLT_SHORT_GRN=6.
- Sub-module approach_decoder:
  - inputs: lamp triple, clock, reset and restart;
  - outputs: current and previous state, dwell count, valid flag, dark-over-tolerance flag;
  - instantiated once for NS and once for EW; the top level does priority encoding and the FSM.

Test Plan:
- Legal cycle: NS G for 10, Y for 3, R, then EW G for 10, Y for 3, R, repeated 3 times (the other approach stays R throughout) -> o_fault=0, code 0, o_flash_req=0 throughout.
- NS_green and EW_green both high at cycle 20 -> o_fault=1 and code=1 in cycle 21; a simultaneous NS MULTI still reports code 1.
- NS GREEN->YELLOW after 4 cycles -> code 6. Separately, NS YELLOW->RED after 2 cycles -> code 4. Separately, NS GREEN->RED directly -> code 5.
- All EW lamps off for 3 cycles with DARK_TOL=2 -> code 3 latched on the 3rd off cycle; a following conflict leaves the code at 3.
- Fault latched, pulse i_fault_clear, drive both approaches RED for 4 cycles -> o_flash_req stays 1 during recovery; o_fault=0 and code 0 after the 4th cycle. Repeat with a non-red at recovery cycle 2 -> the count restarts.
- With FAULT_LOG_EN, trigger 3 separate faults with clears in between -> o_fault_count=3; asserting i_rst mid-FAULT gives all outputs 0 on the next cycle.
